fifo_wr_arb: RTL and testbench



---
 rtl/fifo_ctrl_pkg.sv | 12 +
 rtl/rr_pick2.sv | 18 +
 rtl/fifo_wr_arb.sv | 107 ++++++++++
 tb/tb_fifo_wr_arb.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO-port controllers: FSM encodings and data width default.
package fifo_ctrl_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: one-hot choice among valid requesters, favouring the one not served last.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (valid)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst-granular round-robin arbiter sharing one FIFO write port between two producers.
// Handshake: a beat moves when req_valid[i] & req_ready[i]; ready only ever rises for the granted requester.
module fifo_wr_arb
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BURST_LEN  = 16,
  parameter int SETTLE_CYC = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  input  logic              almost_full,
  input  logic              full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic [1:0]        grant,
  output logic              burst_done
);

  localparam logic [7:0] BURST_LAST  = 8'(BURST_LEN - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_t            state;
  logic [7:0]        beat_cnt;
  logic [7:0]        settle_cnt;
  logic              last;
  logic [1:0]        pick;
  logic              accept;
  logic              owner_valid;
  logic              room;
  logic [DATA_W-1:0] beat_data;

  rr_pick2 u_pick (
    .valid (req_valid),
    .last  (last),
    .pick  (pick)
  );

  assign room        = ~almost_full & ~full;
  assign req_ready   = (state == ST_BURST && room) ? grant : 2'b00;
  assign accept      = |(req_valid & req_ready);
  assign owner_valid = |(req_valid & grant);
  assign beat_data   = grant[1] ? req_data1 : req_data0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_INIT;
      grant      <= 2'b00;
      burst_done <= 1'b0;
      beat_cnt   <= 8'd0;
      settle_cnt <= 8'd0;
      last       <= 1'b1;
    end else begin
      burst_done <= 1'b0;
      case (state)
        ST_INIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 8'd0;
            state      <= ST_IDLE;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        ST_IDLE: begin
          if (pick != 2'b00) begin
            grant    <= pick;
            beat_cnt <= 8'd0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          // A stall (no room) neither counts nor closes; only a real drain or a full burst closes.
          if ((accept && beat_cnt == BURST_LAST) || (room && !owner_valid)) begin
            burst_done <= 1'b1;
            last       <= grant[1];
            grant      <= 2'b00;
            state      <= ST_IDLE;
          end
          if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: begin
          grant <= 2'b00;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      fifo_wr_en <= accept;
      if (accept) begin
        fifo_wdata <= beat_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: two instances (burst 16 and burst 1) share random stimulus and are
// each checked every cycle against a transaction-level model and a write-data queue.
module tb_fifo_wr_arb;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [1:0] req_valid;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic       almost_full;
  logic       full;

  logic [1:0] a_ready, a_grant, b_ready, b_grant;
  logic       a_wr_en, a_done, b_wr_en, b_done;
  logic [7:0] a_wdata, b_wdata;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];

  typedef struct {
    int   phase;   // 0 settling, 1 gap between bursts, 2 in a burst
    int   settle;
    int   beats;
    int   owner;
    int   last;
    bit   wr;
    bit   done;
  } model_t;

  model_t ma, mb;

  fifo_wr_arb #(.DATA_W(8), .BURST_LEN(16), .SETTLE_CYC(10)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(a_ready),
    .almost_full(almost_full), .full(full), .fifo_wr_en(a_wr_en),
    .fifo_wdata(a_wdata), .grant(a_grant), .burst_done(a_done)
  );

  fifo_wr_arb #(.DATA_W(8), .BURST_LEN(1), .SETTLE_CYC(10)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(b_ready),
    .almost_full(almost_full), .full(full), .fifo_wr_en(b_wr_en),
    .fifo_wdata(b_wdata), .grant(b_grant), .burst_done(b_done)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model ----------------
  function automatic model_t model_reset();
    model_t m;
    m.phase = 0; m.settle = 0; m.beats = 0; m.owner = 0; m.last = 1;
    m.wr = 1'b0; m.done = 1'b0;
    return m;
  endfunction

  function automatic logic [1:0] model_ready(model_t m, logic af, logic fl);
    if (m.phase == 2 && !af && !fl) return (m.owner == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] model_grant(model_t m);
    if (m.phase == 2) return (m.owner == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic model_step(inout model_t m, input int burst_len, output bit acc,
                            output logic [7:0] acc_data);
    bit room;
    room     = !almost_full && !full;
    acc      = (m.phase == 2) && room && req_valid[m.owner];
    acc_data = (m.owner == 1) ? req_data1 : req_data0;
    m.wr     = acc;
    m.done   = 1'b0;
    if (m.phase == 0) begin
      m.settle++;
      if (m.settle == 10) begin m.phase = 1; m.settle = 0; end
    end else if (m.phase == 1) begin
      if (req_valid != 2'b00) begin
        if (req_valid == 2'b11) m.owner = 1 - m.last;
        else                    m.owner = req_valid[1] ? 1 : 0;
        m.beats = 0;
        m.phase = 2;
      end
    end else begin
      if (acc) m.beats++;
      if ((acc && m.beats == burst_len) || (room && !req_valid[m.owner])) begin
        m.done  = 1'b1;
        m.last  = m.owner;
        m.phase = 1;
      end
    end
  endtask

  initial begin
    ma = model_reset();
    mb = model_reset();
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        ma = model_reset();
        mb = model_reset();
        exp_a_q.delete();
        exp_b_q.delete();
      end else begin
        bit acc;
        logic [7:0] d;
        model_step(ma, 16, acc, d);
        if (acc) exp_a_q.push_back(d);
        model_step(mb, 1, acc, d);
        if (acc) exp_b_q.push_back(d);
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge sys_clk);
      chk("a_grant", {6'd0, a_grant}, {6'd0, model_grant(ma)});
      chk("a_ready", {6'd0, a_ready}, {6'd0, model_ready(ma, almost_full, full)});
      chk("a_done",  {7'd0, a_done},  {7'd0, ma.done});
      chk("a_wr_en", {7'd0, a_wr_en}, {7'd0, ma.wr});
      if (a_wr_en) begin
        if (exp_a_q.size() == 0) chk("a_wr_spurious", 8'd1, 8'd0);
        else                     chk("a_wdata", a_wdata, exp_a_q.pop_front());
      end
      chk("b_grant", {6'd0, b_grant}, {6'd0, model_grant(mb)});
      chk("b_ready", {6'd0, b_ready}, {6'd0, model_ready(mb, almost_full, full)});
      chk("b_done",  {7'd0, b_done},  {7'd0, mb.done});
      chk("b_wr_en", {7'd0, b_wr_en}, {7'd0, mb.wr});
      if (b_wr_en) begin
        if (exp_b_q.size() == 0) chk("b_wr_spurious", 8'd1, 8'd0);
        else                     chk("b_wdata", b_wdata, exp_b_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input int cycles, input logic [1:0] v, input logic af, input logic fl);
    for (int i = 0; i < cycles; i++) begin
      @(posedge sys_clk);
      #1;
      req_valid   = v;
      req_data0   = 8'($urandom_range(0, 255));
      req_data1   = 8'($urandom_range(0, 255));
      almost_full = af;
      full        = fl;
    end
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("rst_a_wr_en", {7'd0, a_wr_en}, 8'd0);
    chk("rst_a_grant", {6'd0, a_grant}, 8'd0);
    chk("rst_b_grant", {6'd0, b_grant}, 8'd0);
    repeat (cycles) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    req_valid   = 2'b11;
    req_data0   = 8'h00;
    req_data1   = 8'h80;
    almost_full = 1'b0;
    full        = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    drive(90, 2'b11, 1'b0, 1'b0);   // settle, then continuous rotation
    drive(7, 2'b01, 1'b0, 1'b0);    // requester 0 alone, then drain
    drive(4, 2'b00, 1'b0, 1'b0);
    drive(5, 2'b11, 1'b0, 1'b0);    // backpressure mid-burst
    drive(7, 2'b11, 1'b1, 1'b0);
    drive(20, 2'b11, 1'b0, 1'b0);
    drive(3, 2'b10, 1'b0, 1'b1);    // full alone must stall, not close
    drive(4, 2'b00, 1'b0, 1'b0);
    drive(20, 2'b11, 1'b0, 1'b0);
    pulse_reset(2);                 // reset in the middle of a burst
    drive(40, 2'b11, 1'b0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      drive(1, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
      if (i == 700) pulse_reset($urandom_range(1, 3));
    end
    drive(5, 2'b00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
